// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master, MSB first, SCLK generated as a clock-enable divide of clk_i
// Ports: clk_i/rst_ni system clock and async active-low reset; tx_data_i/tx_valid_i/tx_ready_o
// word-in handshake; rx_data_o/rx_valid_o received word with one-cycle strobe; busy_o transfer
// in flight; sclk_o/mosi_o/miso_i/cs_n_o SPI pins.
module spi_master #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              busy_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic              cs_n_o
);
  localparam int H  = CLK_DIV / 2;
  localparam int CW = $clog2(H) + 1;
  localparam int BW = $clog2(DATA_W) + 1;
  if (CLK_DIV < 2 || CLK_DIV % 2 != 0 || DATA_W < 1 || DATA_W > 32) begin : g_bad_param
    $error("spi_master: DATA_W must be 1..32 and CLK_DIV even and >= 2");
  end
  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_e;
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bits_q, bits_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d;
  logic              sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d, rx_valid_q, rx_valid_d;
  logic              tick, accept;
  assign tick = cnt_q == CW'(H - 1);
  // The last GAP cycle already reports ready, so a held tx_valid restarts exactly H cycles after cs_n rises
  assign tx_ready_o = state_q == IDLE || (state_q == GAP && tick);
  assign busy_o     = !tx_ready_o;
  assign accept     = tx_valid_i && tx_ready_o;
  always_comb begin
    state_d    = state_q;
    bits_d     = bits_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rx_data_d  = rx_data_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    rx_valid_d = 1'b0;
    if (accept) begin
      state_d = LEAD;
      bits_d  = '0;
      tx_d    = tx_data_i;
      cs_n_d  = 1'b0;
      mosi_d  = tx_data_i[DATA_W-1];
    end else if (tick) begin
      case (state_q)
        LEAD: begin
          state_d = SHIFT;
          sclk_d  = 1'b1;
          rx_d    = (rx_q << 1) | DATA_W'(miso_i);
        end
        SHIFT: begin
          sclk_d = !sclk_q;
          if (!sclk_q) rx_d = (rx_q << 1) | DATA_W'(miso_i);
          else if (bits_q == BW'(DATA_W - 1)) state_d = TRAIL;
          else begin
            bits_d = bits_q + 1'b1;
            tx_d   = tx_q << 1;
            mosi_d = tx_d[DATA_W-1];
          end
        end
        TRAIL: begin
          state_d    = GAP;
          cs_n_d     = 1'b1;
          mosi_d     = 1'b0;
          rx_data_d  = rx_q;
          rx_valid_d = 1'b1;
        end
        GAP:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    cnt_d = (state_d != state_q || state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bits_q     <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rx_data_q  <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bits_q     <= bits_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rx_data_q  <= rx_data_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      rx_valid_q <= rx_valid_d;
    end
  end
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign sclk_o     = sclk_q;
  assign mosi_o     = mosi_q;
  assign cs_n_o     = cs_n_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scoreboard bench for spi_master (8-bit/div-4 and 16-bit/div-2 instances)
module tb_spi_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0, checks = 0, fails = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic rst_n;
  logic [7:0] tx_data_a, rx_data_a, slave_a, mosi_sh;
  logic tx_valid_a, tx_ready_a, rx_valid_a, busy_a, sclk_a, mosi_a, miso_a, cs_n_a, loop_a;
  logic [15:0] tx_data_b, rx_data_b;
  logic tx_valid_b, tx_ready_b, rx_valid_b, busy_b, sclk_b, mosi_b, cs_n_b;
  int pulses_a = 0, rx_cnt_a = 0, run = 0, last_t0 = 0, last_tb = 0;
  logic prev_s = 1'b0;
  typedef struct { logic [7:0] tx; logic [7:0] rx; int t0; } exp_t;
  typedef struct { logic [15:0] rx; int t0; } expb_t;
  exp_t sb[$];
  expb_t sb_b[$];
  exp_t ea;
  expb_t eb;
  // slave side: loopback, or shift out slave_a MSB first, next bit presented after each SCLK rise
  assign miso_a = loop_a ? mosi_a : (pulses_a < 8 ? slave_a[7 - pulses_a] : 1'b0);
  spi_master #(.DATA_W(8), .CLK_DIV(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(tx_data_a), .tx_valid_i(tx_valid_a),
    .tx_ready_o(tx_ready_a), .rx_data_o(rx_data_a), .rx_valid_o(rx_valid_a), .busy_o(busy_a),
    .sclk_o(sclk_a), .mosi_o(mosi_a), .miso_i(miso_a), .cs_n_o(cs_n_a));
  spi_master #(.DATA_W(16), .CLK_DIV(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(tx_data_b), .tx_valid_i(tx_valid_b),
    .tx_ready_o(tx_ready_b), .rx_data_o(rx_data_b), .rx_valid_o(rx_valid_b), .busy_o(busy_b),
    .sclk_o(sclk_b), .mosi_o(mosi_b), .miso_i(mosi_b), .cs_n_o(cs_n_b));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic err(input string name);
    checks++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask
  always @(posedge sclk_a or negedge cs_n_a)
    if (sclk_a) begin
      mosi_sh = {mosi_sh[6:0], mosi_a};
      pulses_a++;
    end else begin
      mosi_sh = '0;
      pulses_a = 0;
    end
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy_vs_ready_a", 32'(busy_a), 32'(!tx_ready_a));
      chk("busy_vs_ready_b", 32'(busy_b), 32'(!tx_ready_b));
      if (rx_valid_a) begin
        rx_cnt_a++;
        if (sb.size() == 0) err("unexpected_rx_valid_a");
        else begin
          ea = sb.pop_front();
          chk("rx_data_a", 32'(rx_data_a), 32'(ea.rx));
          chk("mosi_word_a", 32'(mosi_sh), 32'(ea.tx));
          chk("sclk_pulses_a", 32'(pulses_a), 32'd8);
          chk("rx_latency_a", 32'(cyc - ea.t0), 32'd34);
          chk("cs_n_at_rx_valid_a", 32'(cs_n_a), 32'd1);
        end
      end
      if (cs_n_a) begin
        run = 0;
        prev_s = 1'b0;
      end else if (sclk_a == prev_s) run++;
      else begin
        chk("sclk_half_period_a", 32'(run), 32'd2);
        run = 1;
        prev_s = sclk_a;
      end
      if (rx_valid_b) begin
        if (sb_b.size() == 0) err("unexpected_rx_valid_b");
        else begin
          eb = sb_b.pop_front();
          chk("rx_data_b", 32'(rx_data_b), 32'(eb.rx));
          chk("rx_latency_b", 32'(cyc - eb.t0), 32'd33);
        end
      end
    end
  end
  task automatic send_a(input logic [7:0] d, input logic lb, input logic [7:0] sw, input bit hold);
    int n = 0;
    while (!tx_ready_a && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) err("ready_timeout_a");
    tx_data_a = d;
    tx_valid_a = 1'b1;
    loop_a = lb;
    slave_a = sw;
    sb.push_back('{d, lb ? d : sw, cyc + 1});
    last_t0 = cyc + 1;
    @(negedge clk);
    if (!hold) tx_valid_a = 1'b0;
  endtask
  task automatic send_b(input logic [15:0] d);
    int n = 0;
    while (!tx_ready_b && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) err("ready_timeout_b");
    tx_data_b = d;
    tx_valid_b = 1'b1;
    sb_b.push_back('{d, cyc + 1});
    last_tb = cyc + 1;
    @(negedge clk);
    tx_valid_b = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || sb_b.size() != 0 || !tx_ready_a || !tx_ready_b) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) err("idle_timeout");
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end
  initial begin
    int t1, hi, n, c0;
    rst_n = 1'b0;
    tx_valid_a = 1'b0;
    tx_data_a = '0;
    loop_a = 1'b1;
    slave_a = '0;
    tx_valid_b = 1'b0;
    tx_data_b = '0;
    repeat (2) @(negedge clk);
    chk("reset_sclk", 32'(sclk_a), 32'd0);
    chk("reset_cs_n", 32'(cs_n_a), 32'd1);
    chk("reset_mosi", 32'(mosi_a), 32'd0);
    chk("reset_rx_data", 32'(rx_data_a), 32'd0);
    chk("reset_rx_valid", 32'(rx_valid_a), 32'd0);
    chk("reset_tx_ready", 32'(tx_ready_a), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    send_a(8'hA5, 1'b1, 8'h00, 1'b0);
    repeat (34) @(negedge clk);
    chk("t1_ready_at_34", 32'(tx_ready_a), 32'd0);
    chk("t1_cs_n_at_34", 32'(cs_n_a), 32'd1);
    @(negedge clk);
    chk("t1_ready_at_35", 32'(tx_ready_a), 32'd1);
    send_a(8'($urandom), 1'b0, 8'hFF, 1'b0);
    send_a(8'($urandom), 1'b0, 8'h00, 1'b0);
    wait_idle();
    fork
      begin
        send_a(8'h3C, 1'b1, 8'h00, 1'b1);
        t1 = last_t0;
        send_a(8'hC3, 1'b1, 8'h00, 1'b0);
        chk("b2b_accept_spacing", 32'(last_t0 - t1), 32'd36);
      end
      begin
        n = 0;
        while (cs_n_a !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        while (cs_n_a !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        hi = 0;
        while (cs_n_a === 1'b1 && hi < 100) begin hi++; @(negedge clk); end
        chk("b2b_cs_n_high_cycles", 32'(hi), 32'd2);
      end
    join
    wait_idle();
    c0 = rx_cnt_a;
    send_a(8'h69, 1'b1, 8'h00, 1'b0);
    repeat (9) @(negedge clk);
    tx_data_a = 8'hFF;
    tx_valid_a = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);
    chk("busy_pulse_single_rx", 32'(rx_cnt_a - c0), 32'd1);
    send_a(8'h77, 1'b1, 8'h00, 1'b0);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_sclk", 32'(sclk_a), 32'd0);
    chk("async_reset_cs_n", 32'(cs_n_a), 32'd1);
    chk("async_reset_mosi", 32'(mosi_a), 32'd0);
    chk("async_reset_rx_valid", 32'(rx_valid_a), 32'd0);
    sb.delete();
    c0 = rx_cnt_a;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_a(8'h5A, 1'b1, 8'h00, 1'b0);
    chk("accept_right_after_reset", 32'(last_t0 - cyc), 32'd0);
    wait_idle();
    chk("reset_single_rx", 32'(rx_cnt_a - c0), 32'd1);
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      send_a(8'($urandom), 1'($urandom), 8'($urandom), 1'b0);
    end
    wait_idle();
    send_b(16'h8001);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      chk("b_sclk_toggle", 32'(sclk_b), 32'(k % 2));
    end
    for (int i = 0; i < 6; i++) send_b(16'($urandom));
    wait_idle();
    repeat (10) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size() + sb_b.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
